dmem_lsu: RTL and testbench

- Load/store unit between the pipeline memory stage and the word-organised data memory (async read, sync write, word-indexed).
- Turns byte-addressed byte/word loads and stores into word reads and read-modify-write word writes.
- Splits misaligned word accesses into two word accesses.
- Returns load data sign- or zero-extended through a one-entry registered response.

---
 rtl/dmem_lsu.sv | 112 +++++++++++
 tb/tb_dmem_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a word-organised data memory.
// Byte/word loads and stores are turned into word reads and read-modify-write word writes; misaligned words take two cycles.
module dmem_lsu #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    localparam int MEM_AW    = ADDR_WIDTH - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic                  in_req_we,
    input  logic                  in_req_byte,
    input  logic                  in_req_signed,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [WORD_WIDTH-1:0] in_req_wdata,
    output logic                  out_resp_valid,
    output logic [WORD_WIDTH-1:0] out_resp_rdata,
    output logic [MEM_AW-1:0]     out_mem_addr_rd,
    output logic [MEM_AW-1:0]     out_mem_addr_wr,
    output logic [WORD_WIDTH-1:0] out_mem_wdata,
    output logic                  out_mem_write_en,
    input  logic [WORD_WIDTH-1:0] in_mem_rdata
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_SECOND = 1'b1;

    logic                  state;
    logic                  cap_we;
    logic [WORD_WIDTH-1:0] cap_wdata;
    logic [MEM_AW-1:0]     cap_addr;
    logic [7:0]            cap_lo;

    logic                  accept;
    logic                  misaligned;
    logic [MEM_AW-1:0]     word_idx;
    logic [7:0]            sel_byte;
    logic [WORD_WIDTH-1:0] rdata_next;

    assign word_idx      = in_req_addr[ADDR_WIDTH-1:1];
    assign misaligned    = !in_req_byte && in_req_addr[0];
    assign out_req_ready = (state == STATE_IDLE) && !reset;
    assign accept        = in_req_valid && out_req_ready;
    assign sel_byte      = in_req_addr[0] ? in_mem_rdata[15:8] : in_mem_rdata[7:0];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        out_mem_addr_rd  = word_idx;
        out_mem_addr_wr  = word_idx;
        out_mem_wdata    = '0;
        out_mem_write_en = 1'b0;
        rdata_next       = '0;
        if (state == STATE_SECOND) begin
            // Second half: read/write the following word (wraps at the top of memory).
            out_mem_addr_rd = cap_addr;
            out_mem_addr_wr = cap_addr;
            if (cap_we) begin
                out_mem_write_en = !reset;
                out_mem_wdata    = {in_mem_rdata[15:8], cap_wdata[15:8]};
            end else begin
                rdata_next = {in_mem_rdata[7:0], cap_lo};
            end
        end else if (accept) begin
            if (in_req_we) begin
                out_mem_write_en = 1'b1;
                if (in_req_byte || misaligned) begin
                    out_mem_wdata = in_req_addr[0] ? {in_req_wdata[7:0], in_mem_rdata[7:0]}
                                                   : {in_mem_rdata[15:8], in_req_wdata[7:0]};
                end else begin
                    out_mem_wdata = in_req_wdata;
                end
            end else if (in_req_byte) begin
                rdata_next = in_req_signed ? {{8{sel_byte[7]}}, sel_byte} : {8'h00, sel_byte};
            end else begin
                rdata_next = in_mem_rdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= STATE_IDLE;
            out_resp_valid <= 1'b0;
            out_resp_rdata <= '0;
            cap_we         <= 1'b0;
            cap_wdata      <= '0;
            cap_addr       <= '0;
            cap_lo         <= '0;
        end else begin
            out_resp_valid <= 1'b0;
            if (state == STATE_SECOND) begin
                state          <= STATE_IDLE;
                out_resp_valid <= 1'b1;
                out_resp_rdata <= rdata_next;
            end else if (accept) begin
                if (misaligned) begin
                    state     <= STATE_SECOND;
                    cap_we    <= in_req_we;
                    cap_wdata <= in_req_wdata;
                    cap_addr  <= word_idx + MEM_AW'(1);
                    cap_lo    <= in_mem_rdata[15:8];
                end else begin
                    out_resp_valid <= 1'b1;
                    out_resp_rdata <= rdata_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: behavioural word memory, table of requests, scoreboard queue for responses.
module tb_dmem_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic        in_req_we = 1'b0;
    logic        in_req_byte = 1'b0;
    logic        in_req_signed = 1'b0;
    logic [11:0] in_req_addr = '0;
    logic [15:0] in_req_wdata = '0;
    logic        out_resp_valid;
    logic [15:0] out_resp_rdata;
    logic [10:0] out_mem_addr_rd;
    logic [10:0] out_mem_addr_wr;
    logic [15:0] out_mem_wdata;
    logic        out_mem_write_en;
    logic [15:0] in_mem_rdata;

    logic [15:0] mem [0:2047];
    logic        bd_we = 1'b0;
    logic [10:0] bd_addr = '0;
    logic [15:0] bd_data = '0;
    int          wr_count = 0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        we;
        logic        is_byte;
        logic        sgn;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_writes;
    } req_t;

    always #5 clock = ~clock;

    dmem_lsu dut (
        .clock           (clock),
        .reset           (reset),
        .in_req_valid    (in_req_valid),
        .out_req_ready   (out_req_ready),
        .in_req_we       (in_req_we),
        .in_req_byte     (in_req_byte),
        .in_req_signed   (in_req_signed),
        .in_req_addr     (in_req_addr),
        .in_req_wdata    (in_req_wdata),
        .out_resp_valid  (out_resp_valid),
        .out_resp_rdata  (out_resp_rdata),
        .out_mem_addr_rd (out_mem_addr_rd),
        .out_mem_addr_wr (out_mem_addr_wr),
        .out_mem_wdata   (out_mem_wdata),
        .out_mem_write_en(out_mem_write_en),
        .in_mem_rdata    (in_mem_rdata)
    );

    assign in_mem_rdata = mem[out_mem_addr_rd];

    // Memory model: async read, sync write; the backdoor port only preloads while the DUT is idle.
    always @(posedge clock) begin
        if (out_mem_write_en) begin
            mem[out_mem_addr_wr] <= out_mem_wdata;
            wr_count             <= wr_count + 1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (out_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(out_resp_rdata), 32'hFFFF_FFFF);
            end else begin
                check("resp_rdata", 32'(out_resp_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        @(negedge clock);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    task automatic issue(input req_t r);
        int  start_wr;
        int  lat;
        bit  mis;
        bit  got;
        mis = !r.is_byte && r.addr[0];
        @(negedge clock);
        in_req_we     = r.we;
        in_req_byte   = r.is_byte;
        in_req_signed = r.sgn;
        in_req_addr   = r.addr;
        in_req_wdata  = r.wdata;
        in_req_valid  = 1'b1;
        start_wr      = wr_count;
        check("ready_idle", 32'(out_req_ready), 32'd1);
        exp_q.push_back(r.exp_rdata);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4 && !got; i++) begin
            @(negedge clock);
            if (i == 1) begin
                in_req_valid = 1'b0;
                if (mis) check("ready_in_second", 32'(out_req_ready), 32'd0);
            end
            if (out_resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) begin
            check("resp_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            check("latency", 32'(lat), mis ? 32'd2 : 32'd1);
        end
        check("write_count", 32'(wr_count - start_wr), 32'(r.exp_writes));
    endtask

    req_t vec[17];

    initial begin
        vec[0]  = '{1'b1, 1'b0, 1'b0, 12'h004, 16'hBEEF, 16'h0000, 1};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 12'h004, 16'h0000, 16'hBEEF, 0};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 12'h007, 16'h0000, 16'hFF80, 0};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 12'h007, 16'h0000, 16'h0080, 0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 12'h006, 16'h0000, 16'hFFF0, 0};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 12'h006, 16'h0000, 16'h00F0, 0};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 12'h00B, 16'h77AB, 16'h0000, 1};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 12'h00A, 16'h0000, 16'hAB34, 0};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 12'h001, 16'h0000, 16'h3322, 0};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 12'h001, 16'hCDEF, 16'h0000, 2};
        vec[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hEF11, 0};
        vec[11] = '{1'b0, 1'b0, 1'b0, 12'h002, 16'h0000, 16'h44CD, 0};
        vec[12] = '{1'b1, 1'b0, 1'b0, 12'hFFF, 16'h9A78, 16'h0000, 2};
        vec[13] = '{1'b0, 1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h9A78, 0};
        vec[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hEF9A, 0};
        vec[15] = '{1'b1, 1'b1, 1'b0, 12'h00A, 16'h335C, 16'h0000, 1};
        vec[16] = '{1'b0, 1'b0, 1'b0, 12'h00A, 16'h0000, 16'hAB5C, 0};

        @(negedge clock);
        check("rst_ready", 32'(out_req_ready), 32'd0);
        check("rst_resp_valid", 32'(out_resp_valid), 32'd0);
        check("rst_resp_rdata", 32'(out_resp_rdata), 32'd0);
        check("rst_write_en", 32'(out_mem_write_en), 32'd0);
        reset = 1'b0;

        preload(11'd0, 16'h2211);
        preload(11'd1, 16'h4433);
        preload(11'd3, 16'h80F0);
        preload(11'd5, 16'h1234);
        preload(11'd10, 16'h1111);
        preload(11'd11, 16'h2222);
        preload(11'd2047, 16'h5566);

        for (int i = 0; i < 17; i++) issue(vec[i]);

        check("mem_w2", 32'(mem[2]), 32'h0000_BEEF);
        check("mem_w3", 32'(mem[3]), 32'h0000_80F0);
        check("mem_w5", 32'(mem[5]), 32'h0000_AB5C);
        check("mem_w0", 32'(mem[0]), 32'h0000_EF9A);
        check("mem_w1", 32'(mem[1]), 32'h0000_44CD);
        check("mem_w2047", 32'(mem[2047]), 32'h0000_7866);

        // Reset lands while a misaligned store is in its second cycle.
        @(negedge clock);
        in_req_we    = 1'b1;
        in_req_byte  = 1'b0;
        in_req_addr  = 12'h015;
        in_req_wdata = 16'h3344;
        in_req_valid = 1'b1;
        @(negedge clock);
        in_req_valid = 1'b0;
        check("mid_ready_second", 32'(out_req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_write_en", 32'(out_mem_write_en), 32'd0);
        check("mid_rst_ready", 32'(out_req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(out_req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(out_resp_valid), 32'd0);
        check("mem_w10_first_half", 32'(mem[10]), 32'h0000_4411);
        check("mem_w11_untouched", 32'(mem[11]), 32'h0000_2222);
        issue('{1'b0, 1'b0, 1'b0, 12'h016, 16'h0000, 16'h2222, 0});

        repeat (2) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
